// File: rtl/plic_pkg.sv
// plic_pkg: definitions shared by the PLIC-facing agents.
//   plic_claim_state_t     - claim/complete FSM states
//   PLIC_CLAIM_ADDR        - default claim register address
//   PLIC_COMPLETE_ADDR     - default complete register address
//   plic_id_w(n)           - ID width needed to encode n interrupt sources
//   PLIC_ID_W              - default ID width (32 sources)
package plic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM_RD,
    CLAIM_WAIT,
    SERVE,
    COMPLETE_WR,
    DRAIN
  } plic_claim_state_t;

  localparam logic [31:0] PLIC_CLAIM_ADDR    = 32'h0000_0004;
  localparam logic [31:0] PLIC_COMPLETE_ADDR = 32'h0000_0008;

  // Smallest w (at least 1) with 2**w >= n.
  function automatic int plic_id_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int PLIC_ID_W = plic_id_w(32);

endpackage

// File: rtl/plic_claim_master.sv
// plic_claim_master: initiator-side agent for the PLIC register interface.
// Claims the winning interrupt by reading the claim register, presents the
// ID to the core, and writes it back to the complete register when the ISR
// is done. A DRAIN phase follows each completion so that a request line that
// has not yet dropped is not re-claimed as stale.
//
// Ports
//   CLK, RST                   clock, synchronous active-high reset
//   interrupt_service_request  PLIC has a pending, enabled interrupt
//   interrupt_clear            PLIC pulse: completed source cleared
//   rdata                      PLIC read data, valid the cycle after ren
//   addr/ren/wen/wdata         PLIC register strobes (single cycle)
//   rambusy                    read in flight (cycle after ren)
//   irq_enable                 core global interrupt enable
//   irq_done                   core pulse: ISR finished
//   irq_valid/irq_id           claimed interrupt presented to the core
//   spurious_count             saturating count of claims returning no ID
module plic_claim_master
  import plic_pkg::*;
#(
  parameter int          N_interrupts  = 32,
  parameter int          ID_W          = PLIC_ID_W,
  parameter logic [31:0] CLAIM_ADDR    = PLIC_CLAIM_ADDR,
  parameter logic [31:0] COMPLETE_ADDR = PLIC_COMPLETE_ADDR,
  parameter int          DRAIN_MAX     = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            interrupt_service_request,
  input  logic            interrupt_clear,
  input  logic [31:0]     rdata,
  output logic [31:0]     addr,
  output logic            ren,
  output logic            wen,
  output logic [31:0]     wdata,
  output logic            rambusy,
  input  logic            irq_enable,
  input  logic            irq_done,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  output logic [7:0]      spurious_count
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);

  plic_claim_state_t state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [3:0]        drain_cnt_q, drain_cnt_d;
  logic [7:0]        spurious_count_q, spurious_count_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              rambusy_q, rambusy_d;
  logic              irq_valid_q, irq_valid_d;
  logic [ID_W-1:0]   irq_id_q, irq_id_d;

  logic [ID_W-1:0]   rd_id;
  logic              rd_id_bad;

  assign rd_id     = rdata[ID_W-1:0];
  assign rd_id_bad = (rd_id == '0) ||
                     ({{(32-ID_W){1'b0}}, rd_id} >= $unsigned(N_interrupts));

  always_comb begin
    state_d          = state_q;
    id_d             = id_q;
    drain_cnt_d      = drain_cnt_q;
    spurious_count_d = spurious_count_q;

    case (state_q)
      IDLE: begin
        if (interrupt_service_request && irq_enable) state_d = CLAIM_RD;
      end
      CLAIM_RD: state_d = CLAIM_WAIT;
      CLAIM_WAIT: begin
        if (rd_id_bad) begin
          if (spurious_count_q != 8'hFF) spurious_count_d = spurious_count_q + 8'd1;
          state_d = IDLE;
        end else begin
          id_d    = rd_id;
          state_d = SERVE;
        end
      end
      // irq_done wins here; interrupt_clear is only meaningful in DRAIN.
      SERVE: begin
        if (irq_done) state_d = COMPLETE_WR;
      end
      COMPLETE_WR: begin
        drain_cnt_d = '0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (interrupt_clear || !interrupt_service_request ||
            drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they belong to.
    ren_d       = (state_d == CLAIM_RD);
    wen_d       = (state_d == COMPLETE_WR);
    rambusy_d   = (state_d == CLAIM_WAIT);
    irq_valid_d = (state_d == SERVE);
    irq_id_d    = irq_valid_d ? id_d : '0;
    addr_d      = ren_d ? CLAIM_ADDR : (wen_d ? COMPLETE_ADDR : 32'h0);
    wdata_d     = wen_d ? {{(32-ID_W){1'b0}}, id_d} : 32'h0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= IDLE;
      id_q             <= '0;
      drain_cnt_q      <= '0;
      spurious_count_q <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      ren_q            <= 1'b0;
      wen_q            <= 1'b0;
      rambusy_q        <= 1'b0;
      irq_valid_q      <= 1'b0;
      irq_id_q         <= '0;
    end else begin
      state_q          <= state_d;
      id_q             <= id_d;
      drain_cnt_q      <= drain_cnt_d;
      spurious_count_q <= spurious_count_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      ren_q            <= ren_d;
      wen_q            <= wen_d;
      rambusy_q        <= rambusy_d;
      irq_valid_q      <= irq_valid_d;
      irq_id_q         <= irq_id_d;
    end
  end

  assign addr           = addr_q;
  assign wdata          = wdata_q;
  assign ren            = ren_q;
  assign wen            = wen_q;
  assign rambusy        = rambusy_q;
  assign irq_valid      = irq_valid_q;
  assign irq_id         = irq_id_q;
  assign spurious_count = spurious_count_q;

endmodule

// File: tb/tb_plic_claim_master.sv
// Bench for plic_claim_master: table of claim vectors plus hand sequences for
// enable gating, DRAIN timeout, ignored pulses, reset in SERVE, saturation and
// a randomized strobe-exclusion run. Claimed IDs go through a scoreboard queue.
module tb_plic_claim_master;

  localparam logic [31:0] CLAIM_A    = 32'h0000_0004;
  localparam logic [31:0] COMPLETE_A = 32'h0000_0008;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req, interrupt_clear, irq_enable, irq_done;
  logic [31:0] rdata;
  logic [31:0] addr, wdata;
  logic        ren, wen, rambusy, irq_valid;
  logic [4:0]  irq_id;
  logic [7:0]  spurious_count;

  plic_claim_master dut (
    .CLK(CLK), .RST(RST),
    .interrupt_service_request(req),
    .interrupt_clear(interrupt_clear),
    .rdata(rdata), .addr(addr), .ren(ren), .wen(wen), .wdata(wdata),
    .rambusy(rambusy), .irq_enable(irq_enable), .irq_done(irq_done),
    .irq_valid(irq_valid), .irq_id(irq_id), .spurious_count(spurious_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd;
    bit          ok;
    logic [4:0]  id;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          exp_spur = 0;
  logic [31:0] served_id = 0;
  logic [4:0]  sb[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bump_spur();
    if (exp_spur < 255) exp_spur++;
  endtask

  // Called with the FSM in IDLE; returns in cycle 3 (SERVE or IDLE).
  task automatic do_claim(input logic [31:0] rd, input bit ok, input logic [4:0] id);
    logic [4:0] e;
    req = 1'b1; irq_enable = 1'b1;
    tick();
    chk("claim_ren", ren, 1'b1);
    chk("claim_addr", addr, CLAIM_A);
    chk("claim_no_wen", wen, 1'b0);
    rdata = rd;
    if (ok) sb.push_back(id);
    tick();
    chk("claim_rambusy", rambusy, 1'b1);
    chk("claim_ren_off", ren, 1'b0);
    req = 1'b0;
    tick();
    rdata = 32'h0;
    chk("claim_valid", irq_valid, ok);
    if (ok) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got empty scoreboard expected an entry");
      end else begin
        e = sb.pop_front();
        chk("claim_id", irq_id, e);
        served_id = {27'h0, e};
      end
    end else begin
      bump_spur();
      chk("spurious_count", spurious_count, exp_spur);
      chk("spurious_idle", rambusy | ren, 1'b0);
    end
  endtask

  // Called in SERVE; completes, then exits DRAIN via interrupt_clear with the
  // request still high, returning in IDLE.
  task automatic finish_serve();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0; req = 1'b1;
    chk("cmp_wen", wen, 1'b1);
    chk("cmp_addr", addr, COMPLETE_A);
    chk("cmp_wdata", wdata, served_id);
    chk("cmp_ren", ren, 1'b0);
    chk("cmp_valid", irq_valid, 1'b0);
    tick();
    chk("drain_wen", wen, 1'b0);
    chk("drain_addr", addr, 32'h0);
    interrupt_clear = 1'b1;
    tick();
    interrupt_clear = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{rd: 32'd7,          ok: 1'b1, id: 5'd7};
    vecs[1] = '{rd: 32'd0,          ok: 1'b0, id: 5'd0};
    vecs[2] = '{rd: 32'd31,         ok: 1'b1, id: 5'd31};
    vecs[3] = '{rd: 32'd1,          ok: 1'b1, id: 5'd1};
    vecs[4] = '{rd: 32'hFFFF_FFE0,  ok: 1'b0, id: 5'd0};
    vecs[5] = '{rd: 32'h0000_0125,  ok: 1'b1, id: 5'd5};

    RST = 1'b1; req = 0; interrupt_clear = 0; irq_enable = 0; irq_done = 0; rdata = 0;
    tick(); tick();
    chk("rst_ren", ren, 1'b0);
    chk("rst_wen", wen, 1'b0);
    chk("rst_valid", irq_valid, 1'b0);
    chk("rst_rambusy", rambusy, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_spur", spurious_count, 8'h0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      do_claim(vecs[i].rd, vecs[i].ok, vecs[i].id);
      if (vecs[i].ok) finish_serve();
    end

    // Enable gating: request held with enable low produces no bus traffic.
    irq_enable = 1'b0; req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gated_ren", ren, 1'b0);
      chk("gated_rambusy", rambusy, 1'b0);
    end
    do_claim(32'd0, 1'b0, 5'd0);

    // Simultaneous done+clear in SERVE, then DRAIN timeout with request high.
    do_claim(32'd12, 1'b1, 5'd12);
    req = 1'b1; irq_done = 1'b1; interrupt_clear = 1'b1;
    tick();
    irq_done = 1'b0; interrupt_clear = 1'b0;
    chk("both_wen", wen, 1'b1);
    chk("both_wdata", wdata, served_id);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("drain_hold", ren | wen, 1'b0);
      tick();
    end
    chk("drain_reclaim", ren, 1'b1);
    rdata = 32'd0; req = 1'b0;
    tick();
    chk("drain_rambusy", rambusy, 1'b1);
    tick();
    bump_spur();
    chk("drain_spur", spurious_count, exp_spur);

    // irq_done outside SERVE is ignored.
    irq_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_done_wen", wen, 1'b0);
      chk("idle_done_valid", irq_valid, 1'b0);
    end
    irq_done = 1'b0;
    req = 1'b1; irq_enable = 1'b1;
    tick();
    chk("wait_done_ren", ren, 1'b1);
    rdata = 32'd3; sb.push_back(5'd3); irq_done = 1'b1;
    tick();
    req = 1'b0;
    tick();
    irq_done = 1'b0; rdata = 32'd0;
    chk("wait_done_valid", irq_valid, 1'b1);
    served_id = {27'h0, sb.pop_front()};
    chk("wait_done_id", irq_id, served_id);
    tick();
    chk("wait_done_still", irq_valid, 1'b1);
    chk("wait_done_nowen", wen, 1'b0);
    finish_serve();

    // Reset while serving: everything drops, no complete write follows.
    do_claim(32'd9, 1'b1, 5'd9);
    RST = 1'b1;
    tick();
    RST = 1'b0; exp_spur = 0;
    chk("srst_valid", irq_valid, 1'b0);
    chk("srst_id", irq_id, 5'd0);
    chk("srst_strobes", {ren, wen, rambusy}, 3'b000);
    chk("srst_bus", addr | wdata, 32'h0);
    chk("srst_spur", spurious_count, 8'h0);
    req = 1'b0; irq_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("srst_no_wen", wen, 1'b0);
    end
    irq_done = 1'b0;

    // Randomized run: strobes exclusive, bus quiet when no strobe.
    for (int i = 0; i < 1000; i++) begin
      req             = 1'($urandom_range(0, 1));
      irq_enable      = ($urandom_range(0, 3) != 0);
      irq_done        = ($urandom_range(0, 3) == 0);
      interrupt_clear = ($urandom_range(0, 3) == 0);
      rdata           = $urandom_range(0, 40);
      tick();
      chk("rand_excl", ren & wen, 1'b0);
      if (!ren && !wen) chk("rand_quiet", addr | wdata, 32'h0);
    end

    // Saturation of the spurious counter.
    req = 0; irq_enable = 0; irq_done = 0; interrupt_clear = 0; rdata = 0;
    RST = 1'b1;
    tick();
    RST = 1'b0; exp_spur = 0;
    for (int i = 0; i < 300; i++) do_claim(32'd0, 1'b0, 5'd0);
    chk("spur_saturated", spurious_count, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plic_claim_master.md
# plic_claim_master

Initiator-side agent for the PLIC register interface. It watches `interrupt_service_request`, reads the PLIC claim register to obtain the winning interrupt ID, and presents that ID to the core. When the core signals ISR completion, it writes the ID back to the PLIC complete register. It sits between the core's interrupt logic and the PLIC, driving the `top`-side signals of the PLIC interface.

## Interface
Parameters:
- N_interrupts, 32, number of interrupt sources; ID 0 is reserved as "none".
- ID_W, 5, width of the interrupt ID; must satisfy 2**ID_W >= N_interrupts.
- CLAIM_ADDR, 32'h0000_0004, PLIC claim register address.
- COMPLETE_ADDR, 32'h0000_0008, PLIC complete register address.
- DRAIN_MAX, 15, maximum number of DRAIN cycles before forced return to IDLE.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- interrupt_service_request  in  1  PLIC has a pending, enabled interrupt above threshold.
- interrupt_clear  in  1  PLIC pulse: pending state of the completed source has been cleared.
- rdata  in  32  PLIC read data; valid in the cycle after `ren`.
- addr  out  32  PLIC register address.
- ren  out  1  read strobe, single cycle.
- wen  out  1  write strobe, single cycle.
- wdata  out  32  write data.
- rambusy  out  1  high while a read is in flight (the cycle after `ren`).
- irq_enable  in  1  core global interrupt enable.
- irq_done  in  1  core pulse: ISR for `irq_id` has finished.
- irq_valid  out  1  claimed interrupt is presented to the core.
- irq_id  out  ID_W  claimed interrupt ID; stable while `irq_valid` is high.
- spurious_count  out  8  saturating count of claims that returned ID 0.

## Operation
FSM states and transitions:
- **IDLE:** when `interrupt_service_request && irq_enable`, go to CLAIM_RD.
- **CLAIM_RD:** `ren=1`, `addr=CLAIM_ADDR`, for one cycle; then go to CLAIM_WAIT.
- **CLAIM_WAIT:** `rambusy=1`. At the end of this cycle, capture `id=rdata[ID_W-1:0]`.
  - If id==0 or id>=N_interrupts: increment `spurious_count` (saturates at 255) and go to IDLE.
  - Otherwise, go to SERVE.
- **SERVE:** `irq_valid=1`, `irq_id=id`. On `irq_done`, go to COMPLETE_WR. Deasserting `irq_enable` in SERVE does not abort.
- **COMPLETE_WR:** `wen=1`, `addr=COMPLETE_ADDR`, `wdata={zeros,id}`, for one cycle; then go to DRAIN.
- **DRAIN:** go to IDLE on `interrupt_clear`, on `!interrupt_service_request`, or after DRAIN_MAX cycles (4-bit counter). This prevents re-claiming a stale request.

Rules:
- `irq_done` is ignored in every state except SERVE.
- `interrupt_clear` is ignored in every state except DRAIN.
- `ren` and `wen` are never high together.
- `addr` and `wdata` are 0 whenever both strobes are low.
- RST asserted in any state returns the FSM to IDLE on the next edge without issuing a complete write. The PLIC is recovered by software.

Reset values: all outputs 0; `spurious_count` 0; FSM in IDLE; stored id 0; drain counter 0.

## Timing
- Request sampled high in IDLE at cycle 0: `ren` in cycle 1, `rambusy` in cycle 2, `irq_valid` in cycle 3.
- `irq_done` sampled at cycle k: `irq_valid` low and `wen` high in cycle k+1.
- Minimum IDLE-to-IDLE time for a served interrupt is 6 cycles. A back-to-back request can start a new claim in the cycle after DRAIN exits.
- If `interrupt_clear` and `irq_done` arrive in the same cycle in SERVE, only `irq_done` acts.
- A DRAIN exit and a still-high request in the same cycle: the FSM goes to IDLE, and the claim starts on the following sample.

## Structure
- Shared package `plic_pkg` holds:
  - `plic_claim_state_t` enum: IDLE, CLAIM_RD, CLAIM_WAIT, SERVE, COMPLETE_WR, DRAIN.
  - Default CLAIM_ADDR and COMPLETE_ADDR constants.
  - `ID_W` localparam helper.
- Single module with no sub-modules. The drain counter and the saturating counter are inline.

## Test plan
- Request with enable, `rdata=7` in CLAIM_WAIT → `ren` at cycle 1, `irq_valid` with `irq_id=7` at cycle 3; `irq_done` → `wen`, `addr=COMPLETE_ADDR`, `wdata=7`; `interrupt_clear` → IDLE.
- Claim returns `rdata=0` → no `irq_valid`, `spurious_count`=1, back in IDLE at cycle 3. 300 such claims → `spurious_count`=255.
- `irq_enable=0` with request high for 10 cycles → no bus activity; enable rises → `ren` 1 cycle later.
- DRAIN with request held high and no `interrupt_clear` → IDLE after exactly DRAIN_MAX cycles, then a new claim read.
- RST asserted in SERVE → next cycle all outputs 0, no `wen` ever issued for that id.
- `irq_done` pulsed in IDLE/CLAIM_WAIT → ignored; `ren`/`wen` mutual exclusion holds across a randomized 1000-cycle run.
